// File: rtl/pc_src_unit_if.sv
// -----------------------------------------------------------------------------
// pc_src_unit_if
//
// Purpose:
//   Bundles the control-side and datapath-side signals of the PC source unit.
//   The control FSM / datapath acts as master. It drives lane data, lane select,
//   write strobes and exception requests. The PC source unit acts as slave. It
//   returns the registered PC, EPC, latched cause and the exception handshake.
//
// Parameters:
//   WIDTH  datapath/PC width in bits
//   NSRC   number of PC source lanes
//   SEL_W  lane select width (2^SEL_W >= NSRC)
//
// Signals (master -> slave):
//   src_sel        lane select (0 = PC+4, 1 = ALUOut, 2 = ALUResult, 3 = jump)
//   src_data       flattened lanes, lane k at [k*WIDTH +: WIDTH]
//   pc_write       unconditional PC load
//   pc_write_cond  conditional PC load (branch)
//   cond_true      branch condition qualifying pc_write_cond
//   exc_req        exception request (level, sampled on clk)
//   exc_cause      exception cause code
//
// Signals (slave -> master):
//   pc, epc, cause, busy, exc_ack
// -----------------------------------------------------------------------------
interface pc_src_unit_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0]      src_sel;
  logic [NSRC*WIDTH-1:0] src_data;
  logic                  pc_write;
  logic                  pc_write_cond;
  logic                  cond_true;
  logic                  exc_req;
  logic [1:0]            exc_cause;

  logic [WIDTH-1:0]      pc;
  logic [WIDTH-1:0]      epc;
  logic [1:0]            cause;
  logic                  busy;
  logic                  exc_ack;

  // Control FSM / datapath side
  modport master (
    output src_sel, src_data, pc_write, pc_write_cond, cond_true,
           exc_req, exc_cause,
    input  pc, epc, cause, busy, exc_ack
  );

  // PC source unit side
  modport slave (
    input  src_sel, src_data, pc_write, pc_write_cond, cond_true,
           exc_req, exc_cause,
    output pc, epc, cause, busy, exc_ack
  );
endinterface

// File: rtl/pc_src_unit.sv
// -----------------------------------------------------------------------------
// pc_src_unit
//
// Purpose:
//   Program-counter source unit for the multicycle MIPS datapath. It selects
//   one of NSRC lanes into an owned PC register, with unconditional and
//   branch-conditional write. It also runs a three-state exception sequencer:
//     RUN      -> normal loads; an exception request moves to EXC_SAVE
//     EXC_SAVE -> epc <= pc - 4
//     EXC_JUMP -> pc  <= EXC_VEC_BASE + 4*cause, back to RUN
//   All outputs are registered or decoded from the state register, so no
//   input reaches an output combinationally.
//
// Parameters:
//   WIDTH, NSRC, SEL_W, RESET_PC, EXC_VEC_BASE
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    pc_src_unit_if.slave (lane inputs, strobes, exception request,
//          pc/epc/cause/busy/exc_ack outputs)
//
// Optional feature:
//   PC_SRC_UNIT_ALIGN_CHECK_EN - when defined, a RUN-state load of a value
//   whose bits [1:0] are non-zero is not performed. It raises a cause-3
//   exception instead. When undefined, the value is loaded verbatim.
// -----------------------------------------------------------------------------
module pc_src_unit #(
  parameter int               WIDTH        = 32,
  parameter int               NSRC         = 4,
  parameter int               SEL_W        = 3,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter logic [WIDTH-1:0] EXC_VEC_BASE = WIDTH'(32'h000000F0)
) (
  input logic          clk,
  input logic          reset,
  pc_src_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_SAVE = 2'd1,
    EXC_JUMP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;

  logic [WIDTH-1:0] laneValue;
  logic             laneValid;
  logic             loadReq;
  logic [WIDTH-1:0] excVector;

  // A load request is either an unconditional write or a branch whose
  // condition evaluated true. It is only honoured in RUN.
  assign loadReq = bus.pc_write | (bus.pc_write_cond & bus.cond_true);

  // The vector uses the latched cause, which is stable from EXC_SAVE onward.
  // The addition wraps modulo 2^WIDTH.
  assign excVector = EXC_VEC_BASE + WIDTH'({cause_q, 2'b00});

  // Lane selection. A select value at or beyond NSRC matches no lane.
  // laneValid then stays low, so the PC simply holds.
  always_comb begin
    laneValue = '0;
    laneValid = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.src_sel == SEL_W'(k)) begin
        laneValue = bus.src_data[k*WIDTH +: WIDTH];
        laneValid = 1'b1;
      end
    end
  end

  // Next-state logic for the sequencer and the PC/EPC/cause registers.
  // In RUN, an exception request beats any same-cycle load, so the PC is
  // not written on that edge. Outside RUN, every control input is ignored.
  // A request still held on return to RUN is therefore simply taken again.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;

    unique case (state_q)
      RUN: begin
        if (bus.exc_req) begin
          state_d = EXC_SAVE;
          cause_d = bus.exc_cause;
        end else if (loadReq && laneValid) begin
`ifdef PC_SRC_UNIT_ALIGN_CHECK_EN
          // A misaligned target is treated exactly like a cause-3 exception
          // request, and the bad value never reaches the PC.
          if (laneValue[1:0] != 2'b00) begin
            state_d = EXC_SAVE;
            cause_d = 2'd3;
          end else begin
            pc_d = laneValue;
          end
`else
          pc_d = laneValue;
`endif
        end
      end

      EXC_SAVE: begin
        // The PC has already advanced past the faulting instruction, so the
        // saved address steps back one word. PC 0 wraps to all-ones minus 3.
        epc_d   = pc_q - WIDTH'(4);
        state_d = EXC_JUMP;
      end

      EXC_JUMP: begin
        pc_d    = excVector;
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any exception sequence at
  // once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Moore outputs. exc_ack marks the single cycle in which the vector is
  // being loaded. That cycle is also the last busy cycle.
  assign bus.pc      = pc_q;
  assign bus.epc     = epc_q;
  assign bus.cause   = cause_q;
  assign bus.busy    = (state_q != RUN);
  assign bus.exc_ack = (state_q == EXC_JUMP);

endmodule

// File: tb/tb_pc_src_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_src_unit
//
// Table-driven vectors for single-cycle PC loads. These are followed by
// hand-written sequences for the exception flow, the alignment behaviour and
// reset in the middle of an exception. Expected outputs are pushed onto a
// scoreboard queue when stimulus is driven. They are popped and compared one
// nanosecond after the following rising edge.
// -----------------------------------------------------------------------------
module tb_pc_src_unit;

  localparam int WIDTH = 32;
  localparam int NSRC  = 4;
  localparam int SEL_W = 3;
  localparam logic [31:0] RST_PC = 32'h00400000;

  // After a load of 0x102 from pc 0xF8, the two builds diverge.
`ifdef PC_SRC_UNIT_ALIGN_CHECK_EN
  localparam logic [31:0] ALIGN_PC    = 32'h000000FC;
  localparam logic [31:0] ALIGN_EPC   = 32'h000000F4;
  localparam logic [1:0]  ALIGN_CAUSE = 2'd3;
`else
  localparam logic [31:0] ALIGN_PC    = 32'h00000102;
  localparam logic [31:0] ALIGN_EPC   = 32'hFFFFFFFC;
  localparam logic [1:0]  ALIGN_CAUSE = 2'd2;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_src_unit_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) bus ();

  pc_src_unit #(
    .WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W),
    .RESET_PC(RST_PC), .EXC_VEC_BASE(32'h000000F0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        busy;
    logic        ack;
  } exp_t;

  typedef struct {
    string             name;
    logic              pw;
    logic              pwc;
    logic              ct;
    logic [2:0]        sel;
    logic [3:0][31:0]  lanes;
    logic [31:0]       expPc;
  } vec_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Single comparison: counts it, and reports a failure on one line
  task automatic compare(input string name, input logic [31:0] act,
                         input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Drives every control input of the unit in one go
  task automatic applyStimulus(input logic pw, input logic pwc, input logic ct,
                               input logic [2:0] sel,
                               input logic [3:0][31:0] lanes,
                               input logic er, input logic [1:0] ec);
    bus.pc_write      = pw;
    bus.pc_write_cond = pwc;
    bus.cond_true     = ct;
    bus.src_sel       = sel;
    bus.src_data      = lanes;
    bus.exc_req       = er;
    bus.exc_cause     = ec;
  endtask

  task automatic expectOut(input string name, input logic [31:0] pc,
                           input logic [31:0] epc, input logic [1:0] cause,
                           input logic busy, input logic ack);
    exp_t e;
    e.name = name; e.pc = pc; e.epc = epc; e.cause = cause;
    e.busy = busy; e.ack = ack;
    expQ.push_back(e);
  endtask

  // Pops the oldest expectation and compares every output against it
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, required 1");
    end else begin
      e = expQ.pop_front();
      compare({e.name, ".pc"},      bus.pc,      e.pc);
      compare({e.name, ".epc"},     bus.epc,     e.epc);
      compare({e.name, ".cause"},   32'(bus.cause),   32'(e.cause));
      compare({e.name, ".busy"},    32'(bus.busy),    32'(e.busy));
      compare({e.name, ".exc_ack"}, 32'(bus.exc_ack), 32'(e.ack));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic vec_t mkVec(input string name, input logic pw,
                                 input logic pwc, input logic ct,
                                 input logic [2:0] sel, input logic [31:0] l0,
                                 input logic [31:0] l1, input logic [31:0] l2,
                                 input logic [31:0] l3, input logic [31:0] expPc);
    vec_t v;
    v.name = name; v.pw = pw; v.pwc = pwc; v.ct = ct; v.sel = sel;
    v.lanes = {l3, l2, l1, l0};
    v.expPc = expPc;
    return v;
  endfunction

  // Watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t             vecs[$];
    logic [3:0][31:0] idleLanes;

    idleLanes = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    vecs.push_back(mkVec("sel2_load",    1, 0, 0, 3'd2, 32'h11, 32'h22, 32'h1234, 32'h44, 32'h00001234));
    vecs.push_back(mkVec("sel5_hold",    1, 0, 0, 3'd5, 32'h11, 32'h22, 32'h33,   32'h44, 32'h00001234));
    vecs.push_back(mkVec("cond_false",   0, 1, 0, 3'd1, 32'h11, 32'h80, 32'h33,   32'h44, 32'h00001234));
    vecs.push_back(mkVec("cond_true",    0, 1, 1, 3'd1, 32'h11, 32'h80, 32'h33,   32'h44, 32'h00000080));
    vecs.push_back(mkVec("no_write",     0, 0, 1, 3'd0, 32'h999, 32'h22, 32'h33,  32'h44, 32'h00000080));
    vecs.push_back(mkVec("sel0_load",    1, 0, 0, 3'd0, 32'h84, 32'h22, 32'h33,   32'h44, 32'h00000084));
    vecs.push_back(mkVec("sel3_load",    1, 0, 0, 3'd3, 32'h11, 32'h22, 32'h33,   32'h00400000, 32'h00400000));
    vecs.push_back(mkVec("sel7_hold",    1, 1, 1, 3'd7, 32'h11, 32'h22, 32'h33,   32'h44, 32'h00400000));
    vecs.push_back(mkVec("sel1_load",    1, 0, 0, 3'd1, 32'h11, 32'h100, 32'h33,  32'h44, 32'h00000100));

    // Reset state
    reset = 1'b1;
    applyStimulus(0, 0, 0, 3'd0, idleLanes, 0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    expectOut("reset", RST_PC, 32'h0, 2'd0, 1'b0, 1'b0);
    checkOutput();
    reset = 1'b0;

    // Single-cycle load vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pw, vecs[i].pwc, vecs[i].ct, vecs[i].sel,
                    vecs[i].lanes, 0, 2'd0);
      expectOut(vecs[i].name, vecs[i].expPc, 32'h0, 2'd0, 1'b0, 1'b0);
      step();
    end

    // Exception beats a same-cycle pc_write; pc=0x100, cause 1
    applyStimulus(1, 0, 0, 3'd2, {32'h0, 32'h5550, 32'h0, 32'h0}, 1, 2'd1);
    expectOut("exc1_save", 32'h100, 32'h0, 2'd1, 1'b1, 1'b0);
    step();
    applyStimulus(1, 0, 0, 3'd2, {32'h0, 32'h5550, 32'h0, 32'h0}, 0, 2'd0);
    expectOut("exc1_jump", 32'h100, 32'hFC, 2'd1, 1'b1, 1'b1);
    step();
    expectOut("exc1_done", 32'hF4, 32'hFC, 2'd1, 1'b0, 1'b0);
    step();

    // Load pc=0, then take a cause-2 exception; pc_write pulses while busy
    applyStimulus(1, 0, 0, 3'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 2'd0);
    expectOut("load_zero", 32'h0, 32'hFC, 2'd1, 1'b0, 1'b0);
    step();
    applyStimulus(0, 0, 0, 3'd2, {32'h0, 32'h7770, 32'h0, 32'h0}, 1, 2'd2);
    expectOut("exc2_save", 32'h0, 32'hFC, 2'd2, 1'b1, 1'b0);
    step();
    applyStimulus(1, 0, 0, 3'd2, {32'h0, 32'h7770, 32'h0, 32'h0}, 0, 2'd0);
    expectOut("exc2_jump", 32'h0, 32'hFFFFFFFC, 2'd2, 1'b1, 1'b1);
    step();
    applyStimulus(1, 1, 1, 3'd2, {32'h0, 32'h7770, 32'h0, 32'h0}, 0, 2'd0);
    expectOut("exc2_done", 32'hF8, 32'hFFFFFFFC, 2'd2, 1'b0, 1'b0);
    step();
    applyStimulus(0, 0, 0, 3'd2, idleLanes, 0, 2'd0);
    expectOut("exc2_hold", 32'hF8, 32'hFFFFFFFC, 2'd2, 1'b0, 1'b0);
    step();

    // Misaligned load of 0x102 from pc 0xF8
    applyStimulus(1, 0, 0, 3'd1, {32'h0, 32'h0, 32'h102, 32'h0}, 0, 2'd0);
`ifdef PC_SRC_UNIT_ALIGN_CHECK_EN
    expectOut("align_save", 32'hF8, 32'hFFFFFFFC, ALIGN_CAUSE, 1'b1, 1'b0);
    step();
    applyStimulus(0, 0, 0, 3'd0, idleLanes, 0, 2'd0);
    expectOut("align_jump", 32'hF8, ALIGN_EPC, ALIGN_CAUSE, 1'b1, 1'b1);
    step();
`else
    expectOut("align_load", ALIGN_PC, ALIGN_EPC, ALIGN_CAUSE, 1'b0, 1'b0);
    step();
    applyStimulus(0, 0, 0, 3'd0, idleLanes, 0, 2'd0);
    expectOut("align_hold", ALIGN_PC, ALIGN_EPC, ALIGN_CAUSE, 1'b0, 1'b0);
    step();
`endif
    expectOut("align_done", ALIGN_PC, ALIGN_EPC, ALIGN_CAUSE, 1'b0, 1'b0);
    step();

    // Reset asserted in EXC_SAVE aborts immediately, without a clock edge
    applyStimulus(0, 0, 0, 3'd0, idleLanes, 1, 2'd1);
    expectOut("rst_pre", ALIGN_PC, ALIGN_EPC, 2'd1, 1'b1, 1'b0);
    step();
    applyStimulus(0, 0, 0, 3'd0, idleLanes, 0, 2'd0);
    #2 reset = 1'b1;
    #1;
    expectOut("rst_mid", RST_PC, 32'h0, 2'd0, 1'b0, 1'b0);
    checkOutput();
    @(posedge clk);
    #1 reset = 1'b0;
    expectOut("rst_after", RST_PC, 32'h0, 2'd0, 1'b0, 1'b0);
    step();

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
